// File: rtl/car_pkg.sv
// car_pkg: shared key indices, wall modes and FSM encoding for the car motion slice.
package car_pkg;
    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int WALL_STOP   = 0;
    localparam int WALL_BOUNCE = 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SPEED = 2'd1;
    localparam logic [1:0] POS   = 2'd2;
endpackage

// File: rtl/car_axis.sv
// car_axis: one axis of car physics, speed accel/friction/saturate then position clip and wall response.
module car_axis
    import car_pkg::*;
#(
    parameter int MAX       = 960,
    parameter int START     = 480,
    parameter int POS_W     = 11,
    parameter int SPD_W     = 8,
    parameter int ACCEL     = 1,
    parameter int FRICTION  = 1,
    parameter int SPEED_MAX = 10,
    parameter int WALL_MODE = WALL_STOP
) (
    input  logic                    pclk,
    input  logic                    rst,
    input  logic                    neg_key,
    input  logic                    pos_key,
    input  logic                    spd_en,
    input  logic                    pos_en,
    output logic [POS_W-1:0]        pos,
    output logic signed [SPD_W-1:0] speed,
    output logic                    clip
);
    localparam int SW = SPD_W + 2;
    localparam int PW = POS_W + 2;
    localparam logic signed [SW-1:0] A  = SW'(ACCEL);
    localparam logic signed [SW-1:0] F  = SW'(FRICTION);
    localparam logic signed [SW-1:0] M  = SW'(SPEED_MAX);
    localparam logic signed [PW-1:0] MX = PW'(MAX);
    logic signed [SW-1:0] s, mag, fr, sum, sat;
    logic signed [PW-1:0] nxt;
    logic lo, hi;
    // Two guard bits keep accel/friction from wrapping before saturation.
    always_comb begin
        s   = {{2{speed[SPD_W-1]}}, speed};
        mag = s < 0 ? -s : s;
        fr  = mag <= F ? '0 : s > 0 ? s - F : s + F;
        sum = neg_key == pos_key ? fr : pos_key ? s + A : s - A;
        sat = sum > M ? M : sum < -M ? -M : sum;
        nxt = $signed({2'b00, pos}) + $signed({{(PW-SPD_W){speed[SPD_W-1]}}, speed});
        lo  = nxt < 0;
        hi  = nxt > MX;
    end
    assign clip = lo | hi;
    always_ff @(posedge pclk) begin
        if (rst) begin
            pos   <= POS_W'(START);
            speed <= '0;
        end else if (spd_en) begin
            speed <= sat[SPD_W-1:0];
        end else if (pos_en) begin
            pos <= lo ? '0 : hi ? POS_W'(MAX) : nxt[POS_W-1:0];
            if (clip) speed <= WALL_MODE == WALL_BOUNCE ? -speed : '0;
        end
    end
endmodule

// File: rtl/car_motion.sv
// car_motion: frame-divided physics tick driving two car_axis instances through IDLE -> SPEED -> POS.
module car_motion
    import car_pkg::*;
#(
    parameter int SCREEN_W    = 1024,
    parameter int SCREEN_H    = 768,
    parameter int CAR_W       = 64,
    parameter int CAR_H       = 64,
    parameter int X_START     = 480,
    parameter int Y_START     = 352,
    parameter int POS_W       = 11,
    parameter int SPD_W       = 8,
    parameter int SPEED_MAX   = 10,
    parameter int ACCEL       = 1,
    parameter int FRICTION    = 1,
    parameter int TICK_FRAMES = 1,
    parameter int WALL_MODE   = WALL_STOP
) (
    input  logic                    pclk,
    input  logic                    rst,
    input  logic                    frame_ended,
    input  logic [3:0]              key,
    output logic [POS_W-1:0]        xpos,
    output logic [POS_W-1:0]        ypos,
    output logic signed [SPD_W-1:0] xspeed,
    output logic signed [SPD_W-1:0] yspeed,
    output logic                    hit_wall,
    output logic                    update_done
);
    localparam int CW = TICK_FRAMES > 1 ? $clog2(TICK_FRAMES) : 1;
    logic [1:0] state;
    logic [CW-1:0] cnt;
    logic [3:0] kq;
    logic tick, cx, cy;
    assign tick = frame_ended && cnt == CW'(TICK_FRAMES - 1);
    // The divider keeps counting even when a tick is dropped because an update is in flight.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            kq          <= '0;
            hit_wall    <= 1'b0;
            update_done <= 1'b0;
        end else begin
            if (frame_ended) cnt <= tick ? '0 : cnt + CW'(1);
            state <= state == IDLE ? (tick ? SPEED : IDLE) : state == SPEED ? POS : IDLE;
            if (state == IDLE && tick) kq <= key;
            hit_wall    <= state == POS && (cx || cy);
            update_done <= state == POS;
        end
    end
    car_axis #(
        .MAX(SCREEN_W - CAR_W), .START(X_START), .POS_W(POS_W), .SPD_W(SPD_W), .ACCEL(ACCEL),
        .FRICTION(FRICTION), .SPEED_MAX(SPEED_MAX), .WALL_MODE(WALL_MODE)
    ) u_x (
        .pclk(pclk), .rst(rst), .neg_key(kq[KEY_LEFT]), .pos_key(kq[KEY_RIGHT]),
        .spd_en(state == SPEED), .pos_en(state == POS), .pos(xpos), .speed(xspeed), .clip(cx)
    );
    car_axis #(
        .MAX(SCREEN_H - CAR_H), .START(Y_START), .POS_W(POS_W), .SPD_W(SPD_W), .ACCEL(ACCEL),
        .FRICTION(FRICTION), .SPEED_MAX(SPEED_MAX), .WALL_MODE(WALL_MODE)
    ) u_y (
        .pclk(pclk), .rst(rst), .neg_key(kq[KEY_UP]), .pos_key(kq[KEY_DOWN]),
        .spd_en(state == SPEED), .pos_en(state == POS), .pos(ypos), .speed(yspeed), .clip(cy)
    );
endmodule

// File: tb/tb_car_motion.sv
// tb_car_motion: directed table-driven checks of car_motion across five parameter sets.
module tb_car_motion;
    logic pclk = 1'b0;
    logic rst = 1'b1;
    logic fe [5];
    logic [3:0] key [5];
    logic [10:0] xp [5], yp [5];
    logic signed [7:0] xs [5], ys [5];
    logic hw [5], ud [5];
    int nud [5];
    int errs = 0, checks = 0;

    always #5 pclk = ~pclk;

    always @(posedge pclk)
        for (int i = 0; i < 5; i++) if (ud[i]) nud[i] <= nud[i] + 1;

    car_motion u0 (.pclk(pclk), .rst(rst), .frame_ended(fe[0]), .key(key[0]), .xpos(xp[0]), .ypos(yp[0]),
        .xspeed(xs[0]), .yspeed(ys[0]), .hit_wall(hw[0]), .update_done(ud[0]));
    car_motion #(.FRICTION(3)) u1 (.pclk(pclk), .rst(rst), .frame_ended(fe[1]), .key(key[1]), .xpos(xp[1]),
        .ypos(yp[1]), .xspeed(xs[1]), .yspeed(ys[1]), .hit_wall(hw[1]), .update_done(ud[1]));
    car_motion #(.X_START(955)) u2 (.pclk(pclk), .rst(rst), .frame_ended(fe[2]), .key(key[2]), .xpos(xp[2]),
        .ypos(yp[2]), .xspeed(xs[2]), .yspeed(ys[2]), .hit_wall(hw[2]), .update_done(ud[2]));
    car_motion #(.X_START(2), .WALL_MODE(1)) u3 (.pclk(pclk), .rst(rst), .frame_ended(fe[3]), .key(key[3]),
        .xpos(xp[3]), .ypos(yp[3]), .xspeed(xs[3]), .yspeed(ys[3]), .hit_wall(hw[3]), .update_done(ud[3]));
    car_motion #(.TICK_FRAMES(2)) u4 (.pclk(pclk), .rst(rst), .frame_ended(fe[4]), .key(key[4]), .xpos(xp[4]),
        .ypos(yp[4]), .xspeed(xs[4]), .yspeed(ys[4]), .hit_wall(hw[4]), .update_done(ud[4]));

    typedef struct { logic [3:0] k; int xs, xp, ys, yp; } vec_t;
    typedef struct { int xs, xp, hit; } wall_t;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    // One tick: pulse frame_ended, expect update_done/hit_wall exactly in the third cycle after.
    task automatic tick(input int d, input logic [3:0] k, input int eh);
        @(negedge pclk); key[d] = k; fe[d] = 1'b1;
        @(negedge pclk); fe[d] = 1'b0;
        @(negedge pclk); chk($sformatf("done_early%0d", d), int'(ud[d]), 0);
        @(negedge pclk); chk($sformatf("done%0d", d), int'(ud[d]), 1);
        chk($sformatf("hit%0d", d), int'(hw[d]), eh);
        @(negedge pclk); chk($sformatf("done_pulse%0d", d), int'(ud[d]), 0);
        chk($sformatf("hit_pulse%0d", d), int'(hw[d]), 0);
    endtask

    task automatic pulse(input int d, input logic [3:0] k);
        @(negedge pclk); key[d] = k; fe[d] = 1'b1;
        @(negedge pclk); fe[d] = 1'b0;
        repeat (4) @(negedge pclk);
    endtask

    initial begin
        vec_t tbl [16];
        wall_t bnc [5];
        int frx [5];
        int base;
        tbl = '{
            '{4'b1000, 1, 481, 0, 352}, '{4'b1000, 2, 483, 0, 352}, '{4'b1000, 3, 486, 0, 352},
            '{4'b1000, 4, 490, 0, 352}, '{4'b1000, 5, 495, 0, 352}, '{4'b1000, 6, 501, 0, 352},
            '{4'b1000, 7, 508, 0, 352}, '{4'b1000, 8, 516, 0, 352}, '{4'b1000, 9, 525, 0, 352},
            '{4'b1000, 10, 535, 0, 352}, '{4'b1000, 10, 545, 0, 352}, '{4'b1000, 10, 555, 0, 352},
            '{4'b1010, 10, 565, 1, 353}, '{4'b0011, 9, 574, 0, 353}, '{4'b0100, 8, 582, 0, 353},
            '{4'b0001, 7, 589, -1, 352}
        };
        bnc = '{'{-1, 1, 0}, '{2, 0, 1}, '{1, 1, 0}, '{0, 1, 0}, '{-1, 0, 0}};
        frx = '{7, 4, 1, 0, 0};
        for (int i = 0; i < 5; i++) begin fe[i] = 1'b0; key[i] = 4'b0; end
        repeat (2) @(negedge pclk);
        chk("rst_xpos", int'(xp[0]), 480);
        chk("rst_ypos", int'(yp[0]), 352);
        chk("rst_xspeed", int'(xs[0]), 0);
        chk("rst_yspeed", int'(ys[0]), 0);
        chk("rst_hit", int'(hw[0]), 0);
        chk("rst_done", int'(ud[0]), 0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick(0, tbl[i].k, 0);
            chk($sformatf("xspeed[%0d]", i), int'(xs[0]), tbl[i].xs);
            chk($sformatf("xpos[%0d]", i), int'(xp[0]), tbl[i].xp);
            chk($sformatf("yspeed[%0d]", i), int'(ys[0]), tbl[i].ys);
            chk($sformatf("ypos[%0d]", i), int'(yp[0]), tbl[i].yp);
        end
        repeat (10) tick(1, 4'b1000, 0);
        chk("fr_start", int'(xs[1]), 10);
        for (int i = 0; i < 5; i++) begin
            tick(1, 4'b0000, 0);
            chk($sformatf("fr_xspeed[%0d]", i), int'(xs[1]), frx[i]);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1, 4'b0011, 0);
            chk($sformatf("fr_yspeed[%0d]", i), int'(ys[1]), 0);
        end
        tick(2, 4'b1000, 0); chk("stop_x1", int'(xp[2]), 956); chk("stop_s1", int'(xs[2]), 1);
        tick(2, 4'b1000, 0); chk("stop_x2", int'(xp[2]), 958); chk("stop_s2", int'(xs[2]), 2);
        tick(2, 4'b1000, 1); chk("stop_x3", int'(xp[2]), 960); chk("stop_s3", int'(xs[2]), 0);
        for (int i = 0; i < 5; i++) begin
            tick(3, 4'b0100, bnc[i].hit);
            chk($sformatf("bnc_xspeed[%0d]", i), int'(xs[3]), bnc[i].xs);
            chk($sformatf("bnc_xpos[%0d]", i), int'(xp[3]), bnc[i].xp);
        end
        base = nud[4];
        repeat (4) pulse(4, 4'b1000);
        chk("div_updates", nud[4] - base, 2);
        chk("div_xspeed", int'(xs[4]), 2);
        chk("div_xpos", int'(xp[4]), 483);
        pulse(4, 4'b1000);
        @(negedge pclk); fe[4] = 1'b1;
        @(negedge pclk);
        @(negedge pclk); fe[4] = 1'b0;
        repeat (4) @(negedge pclk);
        pulse(4, 4'b1000);
        chk("div_drop_updates", nud[4] - base, 4);
        chk("div_drop_xspeed", int'(xs[4]), 4);
        chk("div_drop_xpos", int'(xp[4]), 490);
        base = nud[0];
        @(negedge pclk); key[0] = 4'b1000; fe[0] = 1'b1;
        @(negedge pclk);
        @(negedge pclk); fe[0] = 1'b0;
        repeat (4) @(negedge pclk);
        chk("drop_updates", nud[0] - base, 1);
        chk("drop_xspeed", int'(xs[0]), 8);
        chk("drop_xpos", int'(xp[0]), 597);
        base = nud[0];
        @(negedge pclk); fe[0] = 1'b1;
        @(negedge pclk); fe[0] = 1'b0; rst = 1'b1;
        @(negedge pclk); rst = 1'b0;
        repeat (4) @(negedge pclk);
        chk("abort_updates", nud[0] - base, 0);
        chk("abort_xpos", int'(xp[0]), 480);
        chk("abort_ypos", int'(yp[0]), 352);
        chk("abort_xspeed", int'(xs[0]), 0);
        chk("abort_yspeed", int'(ys[0]), 0);
        chk("abort_hit", int'(hw[0]), 0);
        chk("abort_done", int'(ud[0]), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
